pipe_operand_fifo: RTL and testbench
====================================

// Module: pipe_operand_fifo
// PURPOSE
//   Elastic buffer stage between a producer pipeline register and the consuming FP operator stage.
//   - Absorbs bursts of up to Depth operands.
//   - Drives a registered full/stall back to the producer register bank.
//   - Presents first-word-fall-through data with a valid (rdy) flag to the consumer.
//   - Sits directly downstream of the pipeline data registers: the producer's write enable and
//     write data drive this block's wen and wdata.
// PARAMETERS
//   DataWidth  32  operand width in bits
//   AddrWidth  2   log2 of depth; Depth = 2**AddrWidth entries (AddrWidth >= 1)
// PORTS
//   clk    in   1            single clock, all logic on posedge
//   rst    in   1            synchronous, active-high reset
//   clr    in   1            synchronous flush: discards all entries
//   wen    in   1            producer write request
//   wdata  in   DataWidth    producer write data
//   full   out  1            registered; 1 = no free entry; producer must stall
//   ren    in   1            consumer read/pop request
//   rdata  out  DataWidth    head entry (FWFT); meaningful only while rdy=1
//   rdy    out  1            registered; 1 = at least one entry held
//   ovf    out  1            sticky: write attempted while full
//   udf    out  1            sticky: read attempted while empty
// BEHAVIOUR
//   Storage and state
//   - Storage: Depth x DataWidth array, not reset.
//   - wptr and rptr are AddrWidth bits wide; count is AddrWidth+1 bits wide.
//   - Pointers wrap naturally modulo Depth (Depth-1 -> 0).
//   Handshake
//   - Write accepted iff wen && !full. Accepted data goes to mem[wptr]; wptr+1.
//   - Read accepted iff ren && rdy. rptr+1.
//   - rdata = mem[rptr], combinational from the array; zero-cycle latency on the read port.
//   - Write-to-rdy latency: 1 cycle. Data written in cycle N is visible on rdata with rdy=1 in cycle N+1.
//   - count' = count + wacc - racc.
//   - full' = (count' == Depth); rdy' = (count' != 0). Both outputs are registers, not decodes of count.
//   Boundary conditions
//   - Full with wen=1 and ren=1: read accepted; write rejected, because full is registered.
//     ovf sets. Next cycle: full=0, count=Depth-1.
//   - Empty with wen=1 and ren=1: write accepted; read rejected. udf sets. Next cycle: rdy=1, count=1.
//   - Partially filled (0<count<Depth) with wen=1 and ren=1: both accepted; count unchanged.
//   - Rejected operations never move pointers or alter storage.
//   Clear and reset
//   - Priority: rst > clr > normal operation.
//   - clr=1: wptr, rptr, count, full, rdy, ovf and udf all return to 0 next cycle.
//     wen and ren in that same cycle are ignored; no flag sets.
//   - Reset values: full=0, rdy=0, ovf=0, udf=0, wptr=rptr=count=0. rdata is don't-care.
//   - Reset mid-operation discards all contents. The first write after rst deasserts is accepted normally.
//   - ovf and udf stay set until rst or clr.
// CONFIGURATION
//   PIPE_FIFO_LEVEL_EN
//   - Defined: adds output port level [AddrWidth:0], equal to the internal count register.
//     Reset value 0; cleared by clr; updates on the same edge as full and rdy.
//   - Undefined: no level port and no extra logic. All other behaviour is identical.
// TESTING
//   1. Reset with DataWidth=32, AddrWidth=2
//      -> full=0, rdy=0, ovf=0, udf=0 (level=0 if enabled).
//   2. Write 0x11,0x22,0x33,0x44 on consecutive cycles, ren=0
//      -> rdy=1 one cycle after the first write; full=1 after the fourth write.
//      -> Fifth write of 0x55 is rejected and ovf=1.
//   3. From the full state, hold ren=1 for 4 cycles
//      -> rdata reads 0x11,0x22,0x33,0x44 in order.
//      -> full=0 after the first pop; rdy=0 after the last pop; no udf.
//   4. Stream wen=1 and ren=1 every cycle for 10 cycles starting from count=2
//      -> count stays 2; data order preserved across pointer wrap; ovf=0, udf=0.
//   5. From empty, assert wen=1 and ren=1 together with wdata=0xA5
//      -> udf=1; next cycle rdy=1 and rdata=0xA5.
//   6. Fill 3 entries, then clr=1 with wen=1
//      -> next cycle rdy=0, full=0, ovf=0, udf=0; the wen in the clr cycle is not stored.

Source files
------------

// File: rtl/pipe_operand_fifo.sv
// FWFT elastic operand buffer with registered full/rdy and sticky ovf/udf.
// Define PIPE_FIFO_LEVEL_EN to expose the occupancy count on a level port.
module pipe_operand_fifo #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wen,
    input  logic [DataWidth-1:0] wdata,
    output logic                 full,
    input  logic                 ren,
    output logic [DataWidth-1:0] rdata,
    output logic                 rdy,
    output logic                 ovf,
    output logic                 udf
`ifdef PIPE_FIFO_LEVEL_EN
    ,
    output logic [AddrWidth:0]   level
`endif
);

    localparam int Depth = 2 ** AddrWidth;
    localparam int CW    = AddrWidth + 1;
    localparam logic [AddrWidth:0] DepthCnt = {1'b1, {AddrWidth{1'b0}}};

    logic [DataWidth-1:0] mem_q [Depth];

    logic [AddrWidth-1:0] wptr_q, wptr_d;
    logic [AddrWidth-1:0] rptr_q, rptr_d;
    logic [AddrWidth:0]   count_q, count_d;
    logic                 full_q, full_d;
    logic                 rdy_q, rdy_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 wacc, racc;

    // Acceptance is judged against the registered flags, not the live count.
    assign wacc = wen && !full_q;
    assign racc = ren && rdy_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        full_d  = full_q;
        rdy_d   = rdy_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            full_d  = 1'b0;
            rdy_d   = 1'b0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            wptr_d  = wptr_q + AddrWidth'(wacc);
            rptr_d  = rptr_q + AddrWidth'(racc);
            count_d = count_q + CW'(wacc) - CW'(racc);
            full_d  = (count_d == DepthCnt);
            rdy_d   = (count_d != '0);
            ovf_d   = ovf_q | (wen & full_q);
            udf_d   = udf_q | (ren & ~rdy_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            rdy_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            rdy_q   <= rdy_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage carries no reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (!rst && !clr && wacc) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rptr_q];
    assign full  = full_q;
    assign rdy   = rdy_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;
`ifdef PIPE_FIFO_LEVEL_EN
    assign level = count_q;
`endif

endmodule

// File: tb/tb_pipe_operand_fifo.sv
// Bench for pipe_operand_fifo: directed vector table, hand sequences,
// and random traffic checked against a queue-based model.
module tb_pipe_operand_fifo;

    localparam int DW    = 32;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, clr, wen, ren;
    logic [DW-1:0] wdata;
    logic          full, rdy, ovf, udf;
    logic [DW-1:0] rdata;
`ifdef PIPE_FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mq[$];
    logic          m_ovf, m_udf;

    always #5 clk = ~clk;

    pipe_operand_fifo #(.DataWidth(DW), .AddrWidth(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .wen   (wen),
        .wdata (wdata),
        .full  (full),
        .ren   (ren),
        .rdata (rdata),
        .rdy   (rdy),
        .ovf   (ovf),
        .udf   (udf)
`ifdef PIPE_FIFO_LEVEL_EN
        ,
        .level (level)
`endif
    );

    typedef struct {
        logic          w, r, c;
        logic [DW-1:0] d;
        logic          f, y, o, u;
        logic          cd;
        logic [DW-1:0] q;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic w, logic r, logic c, logic [DW-1:0] d,
                                logic f, logic y, logic o, logic u,
                                logic cd, logic [DW-1:0] q);
        vec_t v;
        v.w = w; v.r = r; v.c = c; v.d = d;
        v.f = f; v.y = y; v.o = o; v.u = u;
        v.cd = cd; v.q = q;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_chk(input string tag);
        chk({tag, " full"}, DW'(full), DW'(mq.size() == DEPTH));
        chk({tag, " rdy"},  DW'(rdy),  DW'(mq.size() != 0));
        chk({tag, " ovf"},  DW'(ovf),  DW'(m_ovf));
        chk({tag, " udf"},  DW'(udf),  DW'(m_udf));
        if (mq.size() != 0) chk({tag, " rdata"}, rdata, mq[0]);
`ifdef PIPE_FIFO_LEVEL_EN
        chk({tag, " level"}, DW'(level), DW'(mq.size()));
`endif
    endtask

    // One clock with the given inputs; model advances from pre-edge occupancy.
    task automatic cyc(input logic w, input logic r, input logic c,
                       input logic [DW-1:0] d, input logic rs, input string tag);
        int n;
        wen = w; ren = r; clr = c; wdata = d; rst = rs;
        @(posedge clk);
        #1;
        n = mq.size();
        if (rs || c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (w && n == DEPTH) m_ovf = 1'b1;
            if (r && n == 0) m_udf = 1'b1;
            if (r && n > 0) void'(mq.pop_front());
            if (w && n < DEPTH) mq.push_back(d);
        end
        model_chk(tag);
    endtask

    initial begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
        rst = 1'b1; clr = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;

        tbl[0]  = mk(1,0,0,32'h11, 0,1,0,0, 1,32'h11);
        tbl[1]  = mk(1,0,0,32'h22, 0,1,0,0, 1,32'h11);
        tbl[2]  = mk(1,0,0,32'h33, 0,1,0,0, 1,32'h11);
        tbl[3]  = mk(1,0,0,32'h44, 1,1,0,0, 1,32'h11);
        tbl[4]  = mk(1,0,0,32'h55, 1,1,1,0, 1,32'h11);
        tbl[5]  = mk(0,1,0,32'h0,  0,1,1,0, 1,32'h22);
        tbl[6]  = mk(0,1,0,32'h0,  0,1,1,0, 1,32'h33);
        tbl[7]  = mk(0,1,0,32'h0,  0,1,1,0, 1,32'h44);
        tbl[8]  = mk(0,1,0,32'h0,  0,0,1,0, 0,32'h0);
        tbl[9]  = mk(0,0,1,32'h0,  0,0,0,0, 0,32'h0);
        tbl[10] = mk(1,1,0,32'hA5, 0,1,0,1, 1,32'hA5);
        tbl[11] = mk(0,0,1,32'h0,  0,0,0,0, 0,32'h0);
        tbl[12] = mk(1,0,0,32'h01, 0,1,0,0, 1,32'h01);
        tbl[13] = mk(1,0,0,32'h02, 0,1,0,0, 1,32'h01);
        tbl[14] = mk(1,0,0,32'h03, 0,1,0,0, 1,32'h01);
        tbl[15] = mk(1,0,1,32'h04, 0,0,0,0, 0,32'h0);
        tbl[16] = mk(1,0,0,32'h77, 0,1,0,0, 1,32'h77);
        tbl[17] = mk(0,0,1,32'h0,  0,0,0,0, 0,32'h0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset full", DW'(full), 0);
        chk("reset rdy",  DW'(rdy),  0);
        chk("reset ovf",  DW'(ovf),  0);
        chk("reset udf",  DW'(udf),  0);
`ifdef PIPE_FIFO_LEVEL_EN
        chk("reset level", DW'(level), 0);
`endif

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d full", i), DW'(full), DW'(tbl[i].f));
            chk($sformatf("vec%0d rdy", i),  DW'(rdy),  DW'(tbl[i].y));
            chk($sformatf("vec%0d ovf", i),  DW'(ovf),  DW'(tbl[i].o));
            chk($sformatf("vec%0d udf", i),  DW'(udf),  DW'(tbl[i].u));
            if (tbl[i].cd) chk($sformatf("vec%0d rdata", i), rdata, tbl[i].q);
        end

        cyc(1, 0, 0, 32'hB0, 0, "pre0");
        cyc(1, 0, 0, 32'hB1, 0, "pre1");
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 32'hC0 + i, 0, $sformatf("strm%0d", i));
            chk($sformatf("strm%0d rdata", i), rdata,
                (i == 0) ? 32'hB1 : 32'hC0 + (i - 1));
            chk($sformatf("strm%0d rdy", i), DW'(rdy), 1);
            chk($sformatf("strm%0d full", i), DW'(full), 0);
            chk($sformatf("strm%0d flags", i), DW'({ovf, udf}), 0);
        end

        cyc(0, 0, 0, 0, 1, "midrst");
        chk("midrst rdy", DW'(rdy), 0);
        cyc(1, 0, 0, 32'hDEAD, 0, "postrst");
        chk("postrst rdata", rdata, 32'hDEAD);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 99) < 3), $urandom,
                ($urandom_range(0, 199) == 0), "rand");
        end

        wen = 1'b0; ren = 1'b0; clr = 1'b0; rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
